// File: rtl/write_out_sequencer.sv
// write_out_sequencer: drives the write_out stage after the systolic array has
// finished a tile. It waits for the array to drain and then accepts one
// quantized row per handshake. Each accepted row becomes a one-cycle SRAM
// write with the row index and target set. Set 0 (SRAM a/b) holds
// 2*ARRAY_SIZE rows and set 1 (SRAM c) holds ARRAY_SIZE rows.
module write_out_sequencer #(
    parameter int ARRAY_SIZE = 8,
    parameter int LAT_WIDTH  = 5,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    input  logic [1:0]           start_data_set,
    input  logic [LAT_WIDTH-1:0] cfg_latency,
    input  logic                 abort,
    input  logic                 row_valid,
    output logic                 row_ready,
    output logic                 sram_write_enable,
    output logic [1:0]           data_set,
    output logic [IDX_WIDTH-1:0] matrix_index,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Index of the final row of a tile, per target set.
    localparam logic [IDX_WIDTH-1:0] LAST_IDX_SET0 = IDX_WIDTH'(2 * ARRAY_SIZE - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX_SET1 = IDX_WIDTH'(ARRAY_SIZE - 1);
    localparam logic [LAT_WIDTH-1:0] LAT_ONE       = LAT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [1:0]           set_q, set_d;
    logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    logic                 we_q, we_d;
    logic [1:0]           ds_q, ds_d;
    logic [IDX_WIDTH-1:0] mi_q, mi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 last_row;

    // Ready depends only on state and abort: an abort cycle never accepts a
    // row, and there is no combinational path from row_valid.
    assign row_ready = (state_q == ST_WRITE) && !abort;
    assign accept    = row_ready && row_valid;
    assign last_row  = set_q[0] ? (idx_q == LAST_IDX_SET1) : (idx_q == LAST_IDX_SET0);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        lat_cnt_d = lat_cnt_q;
        idx_d     = idx_q;
        we_d      = 1'b0;
        ds_d      = 2'd0;
        mi_d      = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    set_d = start_data_set;
                    idx_d = '0;
                    if (start_data_set[1]) begin
                        // Sets 2 and 3 do not exist: report and finish at once.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (cfg_latency == '0) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = cfg_latency;
                    end
                end
            end

            ST_WAIT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    // The counter is loaded with the latency, so one cycle
                    // is spent in WAIT for each count down to 1.
                    lat_cnt_d = lat_cnt_q - LAT_ONE;
                    if (lat_cnt_q == LAT_ONE) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = '0;
                    idx_d     = '0;
                end else if (accept) begin
                    we_d = 1'b1;
                    mi_d = idx_q;
                    ds_d = set_q;
                    if (last_row) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = '0;
                idx_d     = '0;
            end
        endcase

        // Busy follows the state being entered, so it rises the cycle after
        // start and falls together with the final write and done.
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output registers; srst clears everything at once.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q   <= ST_IDLE;
            set_q     <= 2'd0;
            lat_cnt_q <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            ds_q      <= 2'd0;
            mi_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            lat_cnt_q <= lat_cnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            ds_q      <= ds_d;
            mi_q      <= mi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sram_write_enable = we_q;
    assign data_set          = ds_q;
    assign matrix_index      = mi_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule

// File: tb/tb_write_out_sequencer.sv
// Bench for write_out_sequencer. Directed scenarios and random traffic are
// compared cycle by cycle against a tile-level reference model.
module tb_write_out_sequencer;

    localparam int ARRAY_SIZE = 8;
    localparam int LAT_WIDTH  = 5;
    localparam int IDX_WIDTH  = 6;

    logic                 clk;
    logic                 srst;
    logic                 start;
    logic [1:0]           start_data_set;
    logic [LAT_WIDTH-1:0] cfg_latency;
    logic                 abort;
    logic                 row_valid;
    logic                 row_ready;
    logic                 sram_write_enable;
    logic [1:0]           data_set;
    logic [IDX_WIDTH-1:0] matrix_index;
    logic                 busy;
    logic                 done;
    logic                 err;

    write_out_sequencer #(
        .ARRAY_SIZE(ARRAY_SIZE),
        .LAT_WIDTH (LAT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) dut (
        .clk              (clk),
        .srst             (srst),
        .start            (start),
        .start_data_set   (start_data_set),
        .cfg_latency      (cfg_latency),
        .abort            (abort),
        .row_valid        (row_valid),
        .row_ready        (row_ready),
        .sram_write_enable(sram_write_enable),
        .data_set         (data_set),
        .matrix_index     (matrix_index),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Tile-level model: whether a tile is open, drain cycles still to wait,
    // next row number, tile length and target set.
    bit m_active;
    int m_wait;
    int m_next;
    int m_len;
    int m_set;

    // Expected registered outputs for the coming cycle.
    int exp_we, exp_mi, exp_ds, exp_busy, exp_done, exp_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_wait = 0; m_next = 0; m_len = 0; m_set = 0;
        exp_we = 0; exp_mi = 0; exp_ds = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},    int'(sram_write_enable), 0);
        chk({tag, "_mi"},    int'(matrix_index), 0);
        chk({tag, "_ds"},    int'(data_set), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_err"},   int'(err), 0);
        chk({tag, "_ready"}, int'(row_ready), 0);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what this cycle's inputs cause at the next edge.
    task automatic cycle(input logic st, input logic [1:0] ds, input int lat,
                         input logic ab, input logic rv);
        int exp_ready;
        @(negedge clk);
        start          = st;
        start_data_set = ds;
        cfg_latency    = LAT_WIDTH'(lat);
        abort          = ab;
        row_valid      = rv;
        #1;
        exp_ready = (m_active && m_wait == 0 && !ab) ? 1 : 0;
        chk("we",    int'(sram_write_enable), exp_we);
        chk("index", int'(matrix_index), exp_mi);
        chk("set",   int'(data_set), exp_ds);
        chk("busy",  int'(busy), exp_busy);
        chk("done",  int'(done), exp_done);
        chk("err",   int'(err), exp_err);
        chk("ready", int'(row_ready), exp_ready);

        exp_we = 0; exp_mi = 0; exp_ds = 0; exp_done = 0; exp_err = 0;
        if (!m_active) begin
            if (st) begin
                if (ds > 2'd1) begin
                    exp_done = 1;
                    exp_err  = 1;
                end else begin
                    m_active = 1;
                    m_set    = int'(ds);
                    m_wait   = lat;
                    m_next   = 0;
                    m_len    = (ds == 2'd1) ? ARRAY_SIZE : 2 * ARRAY_SIZE;
                end
            end
        end else if (ab) begin
            m_active = 0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (rv) begin
            exp_we = 1;
            exp_mi = m_next;
            exp_ds = m_set;
            m_next++;
            if (m_next == m_len) begin
                m_active = 0;
                exp_done = 1;
            end
        end
        exp_busy = m_active ? 1 : 0;
    endtask

    initial begin
        logic [1:0] rds;
        int         rlat;
        srst = 1'b1; start = 1'b0; start_data_set = 2'd0; cfg_latency = '0;
        abort = 1'b0; row_valid = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        srst = 1'b0;

        // Set 0, latency 3, rows always valid.
        cycle(1, 2'd0, 3, 0, 1);
        repeat (22) cycle(0, 2'd0, 0, 0, 1);

        // Set 1, latency 0, row_valid alternating.
        cycle(1, 2'd1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 2'd0, 0, 0, (i % 2) == 0);

        // Illegal set.
        cycle(1, 2'd2, 0, 0, 1);
        repeat (3) cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd3, 4, 0, 1);
        repeat (3) cycle(0, 2'd0, 0, 0, 1);

        // Abort the cycle after the fifth accept, then restart.
        cycle(1, 2'd0, 0, 0, 1);
        repeat (5) cycle(0, 2'd0, 0, 0, 1);
        cycle(0, 2'd0, 0, 1, 1);
        repeat (2) cycle(0, 2'd0, 0, 0, 1);
        cycle(0, 2'd0, 0, 1, 1);
        cycle(1, 2'd0, 2, 0, 1);
        repeat (2) cycle(0, 2'd0, 0, 0, 1);
        cycle(0, 2'd0, 0, 1, 0);
        cycle(1, 2'd0, 2, 0, 1);
        repeat (22) cycle(0, 2'd0, 0, 0, 1);

        // Start ignored mid-tile, then a new start in the done cycle.
        cycle(1, 2'd1, 1, 0, 1);
        repeat (4) cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd0, 0, 0, 1);
        repeat (4) cycle(0, 2'd0, 0, 0, 1);
        cycle(1, 2'd0, 0, 0, 1);
        repeat (20) cycle(0, 2'd0, 0, 0, 1);

        // Asynchronous reset at index 10 of a set-0 tile.
        cycle(1, 2'd0, 0, 0, 1);
        repeat (11) cycle(0, 2'd0, 0, 0, 1);
        @(negedge clk);
        chk("pre_srst_index", int'(matrix_index), 10);
        #2 srst = 1'b1;
        #1;
        check_all_zero("srst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        repeat (5) cycle(0, 2'd0, 0, 0, 1);

        // Random traffic.
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) rds = 2'($urandom_range(2, 3));
            else                          rds = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rlat = int'($urandom_range(0, 31));
            else                           rlat = int'($urandom_range(0, 3));
            cycle($urandom_range(0, 99) < 8, rds, rlat,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
